alu_issue_ctrl: RTL

- Initiator side of the ALU interface. Accepts one decoded-operand instruction at a time and translates opcode/funct into ALU opCode, operands and shiftAmt.
- Drives the combinational ALU, captures result/overflow/zero, and returns a write-back/branch response over a valid/ready handshake.
- Sits between the register-read stage and the write-back stage of the multi-cycle datapath.

---
 rtl/alu_issue_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Initiator side of the ALU interface in the multi-cycle datapath. It takes
// one decoded-operand MIPS instruction at a time from register read. It
// translates opcode/funct into an ALU opcode, operands and shift amount, and
// drives the external combinational ALU for one cycle. It captures the
// result and flags, then offers a write-back/branch response to the
// write-back stage.
//
// Optional feature macro: ALU_ISSUE_PERF_CNT_EN
//   When defined, this block adds the retired_cnt (32-bit) and exc_cnt
//   (16-bit) outputs. The counters track completed response handshakes and
//   those handshakes that carried an exception.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   instr_valid/ready   instruction + operand handshake from register read
//   instr, rs_val,      raw instruction word and its register operands
//   rt_val
//   alu_in1, alu_in2,   operands and controls driven to the external ALU
//   alu_opCode,         (stable for the whole EXEC cycle)
//   alu_shiftAmt
//   alu_result,         ALU outputs, captured at the end of EXEC
//   alu_overflow,
//   alu_zero
//   wb_valid/ready      response handshake to write-back
//   wb_data, wb_reg,    captured result, destination register, and the
//   wb_en               write-enable qualifier
//   branch_taken        beq/bne outcome
//   exc_overflow        trapping add/sub overflowed
//   exc_illegal         unsupported opcode/funct
//   retired_cnt,        performance counters (only with the macro above)
//   exc_cnt
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_opCode,
  output logic [4:0]       alu_shiftAmt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [REGW-1:0]  wb_reg,
  output logic             wb_en,
  output logic             branch_taken,
  output logic             exc_overflow,
  output logic             exc_illegal
`ifdef ALU_ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]      retired_cnt,
  output logic [15:0]      exc_cnt
`endif
);

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Controller states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;

  // Instruction fields
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       rt_idx;
  logic [4:0]       rd_idx;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] imm_zext;

  assign opcode   = instr[31:26];
  assign rt_idx   = instr[20:16];
  assign rd_idx   = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm_sext = {{(WIDTH-16){instr[15]}}, instr[15:0]};
  assign imm_zext = {{(WIDTH-16){1'b0}}, instr[15:0]};

  // The rs index is consumed upstream (rs_val arrives already read).
  logic unused_rs_idx;
  assign unused_rs_idx = ^instr[25:21];

  // Decode results
  logic [3:0]       dec_op;
  logic [WIDTH-1:0] dec_in1;
  logic [WIDTH-1:0] dec_in2;
  logic [4:0]       dec_shamt;
  logic [REGW-1:0]  dec_dest;
  logic             dec_trap;
  logic             dec_beq;
  logic             dec_bne;
  logic             dec_illegal;

  // NOTE: every signal gets a default before the case so that no path leaves
  // a value unassigned. An unassigned path would infer a latch.
  always_comb begin
    dec_op      = ALU_AND;
    dec_in1     = rs_val;
    dec_in2     = rt_val;
    dec_shamt   = '0;
    dec_dest    = REGW'(rd_idx);
    dec_trap    = 1'b0;
    dec_beq     = 1'b0;
    dec_bne     = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec_op = ALU_ADD; dec_trap = 1'b1; end
          6'h21: dec_op = ALU_ADD;
          6'h22: begin dec_op = ALU_SUB; dec_trap = 1'b1; end
          6'h23: dec_op = ALU_SUB;
          6'h24: dec_op = ALU_AND;
          6'h25: dec_op = ALU_OR;
          6'h27: dec_op = ALU_NOR;
          6'h2A: dec_op = ALU_SLT;
          6'h00: begin dec_op = ALU_SLL; dec_in1 = rt_val; dec_shamt = shamt; end
          6'h02: begin dec_op = ALU_SRL; dec_in1 = rt_val; dec_shamt = shamt; end
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h08: begin dec_op = ALU_ADD; dec_in2 = imm_sext; dec_dest = REGW'(rt_idx); dec_trap = 1'b1; end
      6'h09: begin dec_op = ALU_ADD; dec_in2 = imm_sext; dec_dest = REGW'(rt_idx); end
      6'h0A: begin dec_op = ALU_SLT; dec_in2 = imm_sext; dec_dest = REGW'(rt_idx); end
      6'h0C: begin dec_op = ALU_AND; dec_in2 = imm_zext; dec_dest = REGW'(rt_idx); end
      6'h0D: begin dec_op = ALU_OR;  dec_in2 = imm_zext; dec_dest = REGW'(rt_idx); end
      // Branches compare via subtraction and never write a register.
      6'h04: begin dec_op = ALU_SUB; dec_beq = 1'b1; dec_dest = '0; end
      6'h05: begin dec_op = ALU_SUB; dec_bne = 1'b1; dec_dest = '0; end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Registered decode carried from IDLE into EXEC
  logic [REGW-1:0] dest_q;
  logic            trap_q;
  logic            beq_q;
  logic            bne_q;

  assign instr_ready = (state == IDLE);
  assign wb_valid    = (state == RESP);

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // updates from pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_opCode   <= '0;
      alu_shiftAmt <= '0;
      dest_q       <= '0;
      trap_q       <= 1'b0;
      beq_q        <= 1'b0;
      bne_q        <= 1'b0;
      wb_data      <= '0;
      wb_reg       <= '0;
      wb_en        <= 1'b0;
      branch_taken <= 1'b0;
      exc_overflow <= 1'b0;
      exc_illegal  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            if (dec_illegal) begin
              // No ALU cycle: respond straight away with a cleared payload.
              state        <= RESP;
              wb_data      <= '0;
              wb_reg       <= '0;
              wb_en        <= 1'b0;
              branch_taken <= 1'b0;
              exc_overflow <= 1'b0;
              exc_illegal  <= 1'b1;
            end else begin
              state        <= EXEC;
              alu_in1      <= dec_in1;
              alu_in2      <= dec_in2;
              alu_opCode   <= dec_op;
              alu_shiftAmt <= dec_shamt;
              dest_q       <= dec_dest;
              trap_q       <= dec_trap;
              beq_q        <= dec_beq;
              bne_q        <= dec_bne;
            end
          end
        end
        EXEC: begin
          state        <= RESP;
          wb_data      <= alu_result;
          wb_reg       <= dest_q;
          exc_overflow <= trap_q & alu_overflow;
          exc_illegal  <= 1'b0;
          branch_taken <= (beq_q & alu_zero) | (bne_q & ~alu_zero);
          // A trapped overflow leaves the destination untouched.
          wb_en        <= ~(beq_q | bne_q) & (dest_q != '0) & ~(trap_q & alu_overflow);
        end
        RESP: begin
          if (wb_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_CNT_EN
  // Counters bump on the response handshake itself and wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      exc_cnt     <= '0;
    end else if (wb_valid && wb_ready) begin
      retired_cnt <= retired_cnt + 32'd1;
      if (exc_overflow || exc_illegal) exc_cnt <= exc_cnt + 16'd1;
    end
  end
`endif

endmodule
